mem_access_unit: RTL and testbench

- Sits between the multicycle RV32I datapath and the system memory bus; the datapath's memory-address mux and the control FSM's memory strobes feed it.
- Converts one CPU memory request (fetch, load or store) into a valid/ready bus transaction.
- Generates byte strobes and store-data lane alignment, and sign/zero-extends load data into a registered read-data output.
- Freezes the CPU via `stall` until the transaction completes or times out.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/bus bundle for mem_access_unit: CPU request side plus valid/ready memory bus.
// master = the access unit, slave = the CPU/bus environment that drives requests and answers the bus.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              stall;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, bus_ready, bus_rdata,
    output stall, done, err, rdata, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, bus_ready, bus_rdata,
    input  stall, done, err, rdata, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/mem_access_unit.sv
// CPU fetch/load/store to valid/ready bus bridge; 3 cycles req->done on a zero-wait bus, +1 per wait cycle,
// bus wait stalls the CPU until ready or timeout abort. MISALIGN_TRAP_EN: misaligned half/word aborts without a bus cycle.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         rstn,
  mem_access_unit_if.master mif
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_valid_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [31:0]       bus_wdata_q;
  logic [3:0]        bus_wstrb_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       wdata_d;
  logic [3:0]        wstrb_d;
  logic [31:0]       rdata_d;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              misalign_d;
  logic              timeout_d;

  // Store lane replication and strobes from the request as presented in IDLE
  always_comb begin
    wdata_d = mif.req_wdata;
    wstrb_d = 4'b1111;
    case (mif.req_funct3)
      3'b000: begin
        wdata_d = {4{mif.req_wdata[7:0]}};
        wstrb_d = 4'b0001 << mif.req_addr[1:0];
      end
      3'b001: begin
        wdata_d = {2{mif.req_wdata[15:0]}};
        wstrb_d = mif.req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mif.bus_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mif.bus_rdata[31:16] : mif.bus_rdata[15:0];
    rdata_d  = mif.bus_rdata;
    case (f3_q)
      3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  rdata_d = {24'b0, byte_sel};
      3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  rdata_d = {16'b0, half_sel};
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign_d = ((mif.req_funct3[1:0] == 2'b01) && mif.req_addr[0]) ||
                      ((mif.req_funct3 == 3'b010) && (mif.req_addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  assign timeout_d = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mif.req_valid) begin
            bus_we_q    <= mif.req_we;
            bus_addr_q  <= {mif.req_addr[ADDR_W-1:2], 2'b00};
            bus_wdata_q <= wdata_d;
            bus_wstrb_q <= mif.req_we ? wstrb_d : 4'b0000;
            off_q       <= mif.req_addr[1:0];
            f3_q        <= mif.req_funct3;
            cnt_q       <= '0;
            if (misalign_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q     <= BUS;
              bus_valid_q <= 1'b1;
              err_q       <= 1'b0;
            end
          end
        end
        BUS: begin
          // A ready arriving on the timeout cycle still completes the access
          if (mif.bus_ready) begin
            state_q     <= DONE;
            bus_valid_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
            if (!bus_we_q) rdata_q <= rdata_d;
          end else if (timeout_d) begin
            state_q     <= DONE;
            bus_valid_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mif.stall     = (state_q == BUS) || ((state_q == IDLE) && mif.req_valid);
  assign mif.done      = done_q;
  assign mif.err       = err_q;
  assign mif.rdata     = rdata_q;
  assign mif.bus_valid = bus_valid_q;
  assign mif.bus_we    = bus_we_q;
  assign mif.bus_addr  = bus_addr_q;
  assign mif.bus_wdata = bus_wdata_q;
  assign mif.bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases then random loads/stores with random bus waits and timeouts,
// checked against a byte-lane reference model (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) mif ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rstn(rstn),
    .mif (mif)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_rdata = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  // First byte lane touched by an access of this size
  function automatic int lane_base(input int size, input logic [31:0] addr);
    if (size == 4) return 0;
    if (size == 2) return (addr % 4 >= 2) ? 2 : 0;
    return int'(addr % 4);
  endfunction

  task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3, input int waits,
                            input logic [31:0] brd);
    int          size, base, ncyc, nvalid, exp_lat, exp_nvalid;
    logic        mis, tmo, got_done, sgn;
    logic [3:0]  estrb;
    logic [31:0] ewd, eaddr, eval;
    logic [63:0] v;

    size  = acc_size(we, f3);
    base  = lane_base(size, addr);
    eaddr = addr - (addr % 4);
    estrb = '0;
    ewd   = '0;
    for (int i = 0; i < 4; i++) begin
      if (we && i >= base && i < base + size) estrb[i] = 1'b1;
      ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    sgn = (f3 == 3'd0 || f3 == 3'd1);
    v = {32'b0, brd} >> (8 * base);
    if (size < 4) begin
      v = v & ((64'd1 << (8 * size)) - 64'd1);
      if (sgn && v[8*size-1]) v = v - (64'd1 << (8 * size));
    end
    eval = v[31:0];
`ifdef MISALIGN_TRAP_EN
    mis = (size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0);
`else
    mis = 1'b0;
`endif
    tmo        = !mis && (waits >= TO);
    exp_lat    = mis ? 2 : tmo ? 2 + TO : 3 + waits;
    exp_nvalid = mis ? 0 : tmo ? TO : waits + 1;

    @(negedge clk);
    mif.req_valid  = 1'b1;
    mif.req_we     = we;
    mif.req_addr   = addr;
    mif.req_wdata  = wd;
    mif.req_funct3 = f3;
    mif.bus_ready  = 1'b0;
    #1;
    check_val({tag, " stall_req"}, 32'(mif.stall), 32'd1);

    ncyc = 1; nvalid = 0; got_done = 1'b0;
    while (!got_done && ncyc < 30) begin
      @(posedge clk); #1;
      mif.req_valid  = 1'b0;
      mif.req_addr   = $urandom();
      mif.req_wdata  = $urandom();
      mif.req_funct3 = 3'($urandom_range(0, 7));
      mif.bus_ready  = 1'b0;
      mif.bus_rdata  = $urandom();
      ncyc++;
      if (mif.done) begin
        got_done = 1'b1;
      end else if (mif.bus_valid) begin
        nvalid++;
        check_val({tag, " bus_addr"}, mif.bus_addr, eaddr);
        check_val({tag, " bus_we"}, 32'(mif.bus_we), 32'(we));
        check_val({tag, " bus_wstrb"}, 32'(mif.bus_wstrb), 32'(estrb));
        if (we) check_val({tag, " bus_wdata"}, mif.bus_wdata, ewd);
        check_val({tag, " stall_bus"}, 32'(mif.stall), 32'd1);
        if (nvalid == waits + 1) begin
          mif.bus_ready = 1'b1;
          mif.bus_rdata = brd;
        end
      end
    end

    check_val({tag, " done_seen"}, 32'(got_done), 32'd1);
    check_val({tag, " latency"}, 32'(ncyc), 32'(exp_lat));
    check_val({tag, " valid_cycles"}, 32'(nvalid), 32'(exp_nvalid));
    check_val({tag, " err"}, 32'(mif.err), 32'(mis || tmo));
    check_val({tag, " stall_done"}, 32'(mif.stall), 32'd0);
    check_val({tag, " valid_done"}, 32'(mif.bus_valid), 32'd0);
    if (mis || tmo) model_rdata = '0;
    else if (!we)   model_rdata = eval;
    check_val({tag, " rdata"}, mif.rdata, model_rdata);

    @(posedge clk); #1;
    mif.bus_ready = 1'b0;
    check_val({tag, " done_pulse"}, 32'(mif.done), 32'd0);
    check_val({tag, " err_clr"}, 32'(mif.err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};
    mif.req_valid  = 1'b0;
    mif.req_we     = 1'b0;
    mif.req_addr   = '0;
    mif.req_wdata  = '0;
    mif.req_funct3 = '0;
    mif.bus_ready  = 1'b0;
    mif.bus_rdata  = '0;

    #12;
    check_val("rst stall", 32'(mif.stall), 32'd0);
    check_val("rst done", 32'(mif.done), 32'd0);
    check_val("rst err", 32'(mif.err), 32'd0);
    check_val("rst bus_valid", 32'(mif.bus_valid), 32'd0);
    check_val("rst bus_we", 32'(mif.bus_we), 32'd0);
    check_val("rst rdata", mif.rdata, 32'd0);
    check_val("rst bus_addr", mif.bus_addr, 32'd0);
    check_val("rst bus_wdata", mif.bus_wdata, 32'd0);
    check_val("rst bus_wstrb", 32'(mif.bus_wstrb), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_access("lw_100",   1'b0, 32'h100, 32'h0,        3'b010, 0,  32'hDEADBEEF);
    run_access("sb_103",   1'b1, 32'h103, 32'h000000A5, 3'b000, 0,  32'h0);
    run_access("lb_202",   1'b0, 32'h202, 32'h0,        3'b000, 1,  32'h12F03456);
    run_access("lbu_202",  1'b0, 32'h202, 32'h0,        3'b100, 0,  32'h12F03456);
    run_access("lh_202",   1'b0, 32'h202, 32'h0,        3'b001, 2,  32'h12F03456);
    run_access("sh_102",   1'b1, 32'h102, 32'h0000BEEF, 3'b001, 0,  32'h0);
    run_access("lw_wait3", 1'b0, 32'h400, 32'h0,        3'b010, 3,  32'h01234567);
    run_access("lw_tmo",   1'b0, 32'h500, 32'h0,        3'b010, 99, 32'h0);
    run_access("lw_101",   1'b0, 32'h101, 32'h0,        3'b010, 0,  32'hCAFEF00D);
    run_access("lhu_103",  1'b0, 32'h103, 32'h0,        3'b101, 0,  32'h8765ABCD);

    // Reset pulse while the bus request is outstanding
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_addr = 32'h300; mif.req_funct3 = 3'b010;
    @(posedge clk); #1;
    mif.req_valid = 1'b0;
    @(posedge clk); #1;
    check_val("arst pre_valid", 32'(mif.bus_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_val("arst bus_valid", 32'(mif.bus_valid), 32'd0);
    check_val("arst stall", 32'(mif.stall), 32'd0);
    check_val("arst rdata", mif.rdata, 32'd0);
    model_rdata = '0;
    @(negedge clk);
    rstn = 1'b1;
    run_access("post_arst", 1'b0, 32'h304, 32'h0, 3'b010, 0, 32'h5A5A1234);

    for (int n = 0; n < 300; n++) begin
      logic we;
      logic [2:0] f3;
      int w;
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      w  = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
      run_access($sformatf("rnd%0d", n), we, $urandom(), $urandom(), f3, w, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
